mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch port (IF) and the data port (MEM stage load/store).
- Sits between the pc/mem stages and the external SRAM/bus.
- Raises `stallreq_o` toward ctrl while any requester is waiting.
- Drops results of flushed transactions.
- Enforces a bus timeout so a missing ack cannot hang the pipeline.

Parameters:
- ADDR_W, 32, address width (matches RegBus)
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, cycles `bus_req_o` may stay high without ack before forced completion; 0 disables the timeout
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYC < 2^CNT_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush from ctrl
- if_req_i  in  1  fetch request; held until if_ready_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction
- if_ready_o  out  1  one-cycle completion pulse
- mem_req_i  in  1  data request; held until mem_ready_o
- mem_we_i  in  1  1 = write
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  store data
- mem_rdata_o  out  DATA_W  load data
- mem_ready_o  out  1  one-cycle completion pulse
- bus_err_o  out  1  pulses with ready when completion was forced by timeout
- bus_req_o  out  1  bus request; held until ack or timeout
- bus_we_o  out  1  bus write enable
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_ack_i  in  1  bus completion; may assert in the same cycle `bus_req_o` rises
- bus_rdata_i  in  DATA_W  read data, valid with ack
- stallreq_o  out  1  to ctrl

Behaviour:
- **Reset:** state IDLE; all outputs 0; counter 0; discard flag 0; last_grant = IF.
- **Reset mid-operation:** the transaction is abandoned, `bus_req_o` is 0 from the next cycle, and no ready is produced.
- **States:** IDLE, IF_BUSY, MEM_BUSY.
- **IDLE grant:**
  - Evaluated only when flush_i = 0. With flush_i = 1, no grant is made that cycle.
  - If only mem_req_i: go to MEM_BUSY.
  - If only if_req_i: go to IF_BUSY.
  - If both: grant MEM, unless last_grant = MEM, then grant IF (anti-starvation alternation).
- **Latching a grant:** on the grant edge, addr/we/sel/wdata are latched into the bus_* registers, `bus_req_o` <= 1, counter <= 0, and last_grant is updated.
  - IF grants always drive `bus_we_o` = 0 and `bus_sel_o` = 4'hF.
- **BUSY, on bus_ack_i = 1:**
  - `bus_req_o` <= 0.
  - rdata is registered into the granted port.
  - The granted port's ready <= 1 for exactly one cycle, unless the discard flag is set.
  - State returns to IDLE.
  - Minimum latency: request seen at cycle N → bus_req at N+1 → ready at N+2 with a same-cycle ack.
- **No back-to-back grant:** the next grant is evaluated in the IDLE cycle, so there is at least one idle cycle between bus transactions.
- **Timeout:**
  - In BUSY, the counter increments each cycle without ack.
  - When counter == TIMEOUT_CYC-1 and no ack: treated as a completion with rdata = 0 and `bus_err_o` = 1 alongside ready.
  - Ack and timeout in the same cycle: ack wins, no error.
- **Flush:**
  - flush_i in BUSY sets the discard flag. The bus transaction still runs to ack or timeout (the bus is never aborted, so writes already issued complete).
  - Ready and err are suppressed for a discarded transaction.
  - The discard flag clears on return to IDLE.
- **rdata outputs** hold their last value between pulses. For write completions, `mem_rdata_o` is unchanged.
- **stallreq_o** (combinational) = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o).
- **Widths:** no arithmetic on data. The counter saturates and never wraps while BUSY.

Decomposition:
- Defines.vh additions:
  - state encodings ArbIdle / ArbIfBusy / ArbMemBusy (2 bits)
  - GrantIf / GrantMem
  - default TIMEOUT constant
- One sub-module, arb_timeout_cnt:
  - inputs: clk, rst, clear, enable
  - output: expired
  - parameters: TIMEOUT_CYC, CNT_W
  - when TIMEOUT_CYC = 0, expired is tied to 0

Test Plan:
- **Single fetch:** if_req=1, if_addr=0x0000_0010; bus acks the cycle after bus_req with rdata 0x2401_0005 → bus_addr 0x10, bus_we 0, bus_sel F; if_ready one pulse 3 cycles after request with if_rdata 0x2401_0005; stallreq high until that pulse.
- **Contention:** if_req and mem_req (write, addr 0x100, wdata 0xDEAD_BEEF, sel 4'b0011) both raised from reset, ack 1 cycle after req → MEM served first (bus_we 1, sel 3), then IF. Repeated simultaneous requests alternate MEM, IF, MEM, IF.
- **Flush during fetch:** flush_i pulsed the cycle after the IF grant, ack 3 cycles later → if_ready never pulses; state IDLE after ack; the next fetch completes normally.
- **Timeout:** TIMEOUT_CYC=4, mem read with bus_ack stuck 0 → bus_req drops after 4 cycles; mem_ready=1 with bus_err=1 and mem_rdata=0. Same setup with ack on cycle 4 → no error, rdata from bus.
- **Reset mid-transaction:** rst asserted 2 cycles into MEM_BUSY → next cycle bus_req=0, all ready/err 0, state IDLE; a new IF request after reset is granted normally.
- **Same-cycle ack:** bus model asserts ack combinationally with bus_req → mem_ready exactly 2 cycles after mem_req; one idle cycle before the next grant.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state/grant encodings and default timeout for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle    = 2'd0,
        ArbIfBusy  = 2'd1,
        ArbMemBusy = 2'd2
    } arb_state_t;

    typedef enum logic {
        GrantIf  = 1'b0,
        GrantMem = 1'b1
    } grant_t;

    localparam int unsigned DefTimeout = 255;
    localparam int unsigned DefCntW    = 8;

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// arb_timeout_cnt: counts busy cycles without ack and flags the last permitted cycle.
module arb_timeout_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DefTimeout,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] Last = CNT_W'(TIMEOUT_CYC - 1);
            localparam logic [CNT_W-1:0] Top  = '1;
            logic [CNT_W-1:0] cnt;
            // saturates so a stalled bus can never wrap back below Last
            always_ff @(posedge clk) begin
                if (rst || clear)
                    cnt <= '0;
                else if (enable && cnt != Top)
                    cnt <= cnt + CNT_W'(1);
            end
            assign expired = (cnt == Last);
        end
    endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory bus between instruction fetch and the data port,
// with alternating priority on contention, flush discard and a bus timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = DefTimeout,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              bus_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              stallreq_o
);

    arb_state_t        state, state_next;
    grant_t            last_grant;
    logic              discard;
    logic              if_want, mem_want, pick_mem, pick_if;
    logic              busy, expired, done, drop;
    logic [DATA_W-1:0] resp;

    arb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!busy),
        .enable (busy && !bus_ack_i),
        .expired(expired)
    );

    // a port whose ready is showing this cycle is still holding req; it must not be re-granted
    always_comb begin
        if_want    = if_req_i & ~if_ready_o;
        mem_want   = mem_req_i & ~mem_ready_o;
        pick_mem   = (state == ArbIdle) & ~flush_i & mem_want & (~if_want | (last_grant == GrantIf));
        pick_if    = (state == ArbIdle) & ~flush_i & if_want & ~pick_mem;
        busy       = (state != ArbIdle);
        done       = busy & (bus_ack_i | expired);
        drop       = discard | flush_i;
        resp       = bus_ack_i ? bus_rdata_i : '0;
        state_next = pick_mem ? ArbMemBusy : pick_if ? ArbIfBusy : done ? ArbIdle : state;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ArbIdle;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            bus_err_o   <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            discard     <= 1'b0;
            last_grant  <= GrantIf;
        end else begin
            if_ready_o  <= done & (state == ArbIfBusy) & ~drop;
            mem_ready_o <= done & (state == ArbMemBusy) & ~drop;
            bus_err_o   <= done & ~bus_ack_i & ~drop;
            discard     <= busy & ~done & drop;
            if (pick_mem || pick_if) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= pick_mem & mem_we_i;
                bus_sel_o   <= pick_mem ? mem_sel_i : 4'hF;
                bus_addr_o  <= pick_mem ? mem_addr_i : if_addr_i;
                bus_wdata_o <= pick_mem ? mem_wdata_i : '0;
                last_grant  <= pick_mem ? GrantMem : GrantIf;
            end else if (done) begin
                bus_req_o <= 1'b0;
            end
            if (done && !drop && state == ArbIfBusy)
                if_rdata_o <= resp;
            if (done && !drop && state == ArbMemBusy && !bus_we_o)
                mem_rdata_o <= resp;
        end
    end

    assign stallreq_o = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven transactions plus hand-written contention, flush, reset and
// same-cycle-ack sequences against a small bus model with programmable ack delay.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_sel = '0;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata, bus_rdata;
    logic        if_ready, mem_ready, bus_err, bus_req, bus_we, bus_ack, stallreq;
    logic [3:0]  bus_sel;

    logic        ack_on = 1'b1;
    int          ack_delay = 0;
    logic [31:0] bus_rd = '0;
    logic [7:0]  age;

    int errors = 0, checks = 0;

    mem_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
        .bus_err_o(bus_err), .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack),
        .bus_rdata_i(bus_rdata), .stallreq_o(stallreq)
    );

    always #5 clk = ~clk;

    // bus model: ack once bus_req has been high for ack_delay earlier cycles (0 = same cycle)
    always @(posedge clk) age <= (bus_req && !bus_ack) ? age + 8'd1 : 8'd0;
    assign bus_ack   = ack_on & bus_req & (age == 8'(ack_delay));
    assign bus_rdata = bus_rd;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        logic        ack;
        int          delay;
        logic        exp_we;
        logic [3:0]  exp_sel;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; flush = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   n;
        logic seen;
        bus_rd = v.brdata; ack_on = v.ack; ack_delay = v.delay;
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_sel = v.sel; mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        n = 0; seen = 1'b0;
        while (n < 20 && !seen) begin
            step();
            n++;
            if (n == 1) begin
                chk({tag, ".bus_req"}, 32'(bus_req), 32'd1);
                chk({tag, ".bus_addr"}, bus_addr, v.addr);
                chk({tag, ".bus_we"}, 32'(bus_we), 32'(v.exp_we));
                chk({tag, ".bus_sel"}, 32'(bus_sel), 32'(v.exp_sel));
                chk({tag, ".stall"}, 32'(stallreq), 32'd1);
                if (v.is_mem && v.we) chk({tag, ".bus_wdata"}, bus_wdata, v.wdata);
            end
            seen = v.is_mem ? mem_ready : if_ready;
        end
        chk({tag, ".latency"}, 32'(n), 32'(v.exp_lat));
        chk({tag, ".rdata"}, v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
        chk({tag, ".err"}, 32'(bus_err), 32'(v.exp_err));
        chk({tag, ".req_low"}, 32'(bus_req), 32'd0);
        chk({tag, ".other_ready"}, 32'(v.is_mem ? if_ready : mem_ready), 32'd0);
        chk({tag, ".stall_done"}, 32'(stallreq), 32'd0);
        if_req = 1'b0; mem_req = 1'b0;
        step();
        chk({tag, ".pulse_one"}, 32'(if_ready | mem_ready | bus_err), 32'd0);
        step();
    endtask

    task automatic wait_ready(output int which, output int n);
        which = 0; n = 0;
        while (n < 20 && which == 0) begin
            step();
            n++;
            which = mem_ready ? 1 : if_ready ? 2 : 0;
        end
    endtask

    initial begin
        int which, n, drop_cyc, pulses, errs;
        vec_t v;
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h2401_0005, 1'b1, 1, 1'b0, 4'hF, 3, 32'h2401_0005, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1'b1, 0, 1'b0, 4'hF, 2, 32'hCAFE_F00D, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1, 1'b1, 4'h3, 3, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'h7777_7777, 1'b0, 0, 1'b0, 4'hF, 5, 32'h0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 4'hC, 32'h0000_0304, 32'h0, 32'h55AA_55AA, 1'b1, 3, 1'b0, 4'hC, 5, 32'h55AA_55AA, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0014, 32'h0, 32'h8C22_0000, 1'b1, 2, 1'b0, 4'hF, 4, 32'h8C22_0000, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 4'h0, 32'h0000_0018, 32'h0, 32'h9999_9999, 1'b0, 0, 1'b0, 4'hF, 5, 32'h0, 1'b1};

        do_reset();
        chk("reset.bus_req", 32'(bus_req), 32'd0);
        chk("reset.ready", 32'({if_ready, mem_ready, bus_err}), 32'd0);
        chk("reset.stall", 32'(stallreq), 32'd0);
        chk("reset.rdata", if_rdata | mem_rdata, 32'd0);
        chk("reset.bus_sel", 32'(bus_sel), 32'd0);

        // contention from reset: MEM first, then IF
        ack_on = 1'b1; ack_delay = 1; bus_rd = 32'h0;
        if_req = 1'b1; if_addr = 32'h20;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
        step();
        chk("cont.bus_we", 32'(bus_we), 32'd1);
        chk("cont.bus_sel", 32'(bus_sel), 32'h3);
        chk("cont.bus_addr", bus_addr, 32'h100);
        wait_ready(which, n);
        chk("cont.first", 32'(which), 32'd1);
        mem_req = 1'b0;
        wait_ready(which, n);
        chk("cont.second", 32'(which), 32'd2);
        if_req = 1'b0;
        step(); step();
        // single-winner rounds: last grant was IF, so MEM, IF, MEM
        for (int r = 0; r < 3; r++) begin
            if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
            wait_ready(which, n);
            if_req = 1'b0; mem_req = 1'b0;
            chk($sformatf("alt%0d.winner", r), 32'(which), (r % 2 == 0) ? 32'd1 : 32'd2);
            step(); step();
        end

        do_reset();
        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // flush during fetch: discard, bus still completes
        if_req = 1'b1; if_addr = 32'h40; ack_on = 1'b1; ack_delay = 3; bus_rd = 32'h1234_5678;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; if_req = 1'b0;
        drop_cyc = 0; pulses = 0; errs = 0;
        for (int c = 3; c <= 10; c++) begin
            step();
            if (drop_cyc == 0 && !bus_req) drop_cyc = c;
            pulses += int'(if_ready);
            errs += int'(bus_err);
        end
        chk("flush.ready", 32'(pulses), 32'd0);
        chk("flush.err", 32'(errs), 32'd0);
        chk("flush.req_drop", 32'(drop_cyc), 32'd5);
        chk("flush.state", 32'(dut.state), 32'(ArbIdle));
        chk("flush.if_rdata", if_rdata, 32'h0);
        v = vecs[0]; v.addr = 32'h44; v.brdata = 32'h0102_0304; v.exp_rdata = 32'h0102_0304;
        run_txn(v, "post_flush");

        // reset two cycles into MEM_BUSY
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h80; ack_on = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        chk("rstmid.bus_req", 32'(bus_req), 32'd0);
        chk("rstmid.ready", 32'({if_ready, mem_ready, bus_err}), 32'd0);
        chk("rstmid.state", 32'(dut.state), 32'(ArbIdle));
        rst = 1'b0; mem_req = 1'b0;
        step();
        v = vecs[5]; v.addr = 32'h48;
        run_txn(v, "post_rst");

        // same-cycle ack, then the next grant after one idle cycle
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400; ack_on = 1'b1; ack_delay = 0; bus_rd = 32'hA5A5_0001;
        step();
        chk("sc.bus_req", 32'(bus_req), 32'd1);
        chk("sc.ack", 32'(bus_ack), 32'd1);
        step();
        chk("sc.mem_ready", 32'(mem_ready), 32'd1);
        chk("sc.mem_rdata", mem_rdata, 32'hA5A5_0001);
        chk("sc.idle_gap", 32'(bus_req), 32'd0);
        mem_req = 1'b0; if_req = 1'b1; if_addr = 32'h4C; bus_rd = 32'h0BAD_F00D;
        step();
        chk("sc.if_req", 32'(bus_req), 32'd1);
        chk("sc.if_addr", bus_addr, 32'h4C);
        step();
        chk("sc.if_ready", 32'(if_ready), 32'd1);
        chk("sc.if_rdata", if_rdata, 32'h0BAD_F00D);
        if_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
